// File: rtl/mmu_bus_arbiter_pkg.sv
// Shared bus types and arbiter constants for the two-master MMU port arbiter.
package mmu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_OP_IDLE  = 2'd0,
    BUS_OP_READ  = 2'd1,
    BUS_OP_WRITE = 2'd2
  } bus_op_t;

  typedef enum logic {
    BUS_SIZE_BYTE = 1'b0,
    BUS_SIZE_WORD = 1'b1
  } bus_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    bus_op_t    op;
    bus_size_t  size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_req_t;

  localparam logic [15:0] ARB_TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/mmu_bus_arbiter_if.sv
// One request/response bus port; used for both master links and the MMU link.
interface mmu_bus_arbiter_if;
  import mmu_bus_arbiter_pkg::*;

  // Handshake: req_op != BUS_OP_IDLE is a request and stays stable until the
  // responder pulses resp_done for one cycle; resp_rdata is valid with resp_done.
  bus_op_t     req_op;
  bus_size_t   req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_done;
  logic [15:0] resp_rdata;

  modport master (
    output req_op, req_size, req_addr, req_wdata,
    input  resp_done, resp_rdata
  );

  modport slave (
    input  req_op, req_size, req_addr, req_wdata,
    output resp_done, resp_rdata
  );

endinterface

// File: rtl/mmu_bus_arbiter_timer.sv
// Saturating transaction timer; expired flags the last allowed busy cycle.
module mmu_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT   = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero timeout disables the flag entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Two-master (m0 CPU, m1 DMA) arbiter for the single MMU port, with transaction timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 wins ties.
module mmu_bus_arbiter
  import mmu_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  mmu_bus_arbiter_if.slave   m0,
  mmu_bus_arbiter_if.slave   m1,
  mmu_bus_arbiter_if.master  s,
  output logic               grant,
  output logic               busy,
  output logic               timeout_err,
  output arb_state_t         state
);

  arb_state_t  state_q, state_d;
  bus_req_t    s_req_q, s_req_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;
  logic [1:0]  done_q, done_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic [15:0] resp_v;

  logic        timer_clear, timer_en, expired;
  bus_req_t    req0, req1;
  logic        want0, want1, winner;

  assign req0  = {m0.req_op, m0.req_size, m0.req_addr, m0.req_wdata};
  assign req1  = {m1.req_op, m1.req_size, m1.req_addr, m1.req_wdata};
  assign want0 = (m0.req_op != BUS_OP_IDLE);
  assign want1 = (m1.req_op != BUS_OP_IDLE);

  always_comb begin : pick
    winner = 1'b0;
    if (want0 && want1) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_grant_q;
`else
      winner = 1'b1;
`endif
    end else if (want1) begin
      winner = 1'b1;
    end
  end

  mmu_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin : next_state
    state_d      = state_q;
    s_req_d      = s_req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    tmo_d        = 1'b0;
    done_d       = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    resp_v       = s.resp_rdata;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (want0 || want1) begin
          grant_d      = winner;
          last_grant_d = winner;
          busy_d       = 1'b1;
          s_req_d      = winner ? req1 : req0;
          timer_clear  = 1'b1;
          state_d      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        timer_en = 1'b1;
        // A real completion beats an expiry landing on the same cycle.
        if (s.resp_done || expired) begin
          resp_v          = s.resp_done ? s.resp_rdata : ARB_TIMEOUT_RDATA;
          tmo_d           = ~s.resp_done;
          done_d[grant_q] = 1'b1;
          if (grant_q) rdata1_d = resp_v;
          else         rdata0_d = resp_v;
          s_req_d.op = BUS_OP_IDLE;
          busy_d     = 1'b0;
          state_d    = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      s_req_q      <= '{op: BUS_OP_IDLE, size: BUS_SIZE_BYTE, addr: 16'h0, wdata: 16'h0};
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
      done_q       <= 2'b00;
      rdata0_q     <= 16'h0;
      rdata1_q     <= 16'h0;
    end else begin
      state_q      <= state_d;
      s_req_q      <= s_req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign s.req_op      = s_req_q.op;
  assign s.req_size    = s_req_q.size;
  assign s.req_addr    = s_req_q.addr;
  assign s.req_wdata   = s_req_q.wdata;
  assign m0.resp_done  = done_q[0];
  assign m0.resp_rdata = rdata0_q;
  assign m1.resp_done  = done_q[1];
  assign m1.resp_rdata = rdata1_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Randomised scoreboard bench for mmu_bus_arbiter with a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mmu_bus_arbiter;
  import mmu_bus_arbiter_pkg::*;

  localparam int TMO   = 4;
  localparam int EXP_W = 34;  // {done cycle[15:0], master, timeout, rdata[15:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       grant, busy, timeout_err;
  arb_state_t dbg_state;

  mmu_bus_arbiter_if m0_if ();
  mmu_bus_arbiter_if m1_if ();
  mmu_bus_arbiter_if s_if ();

  mmu_bus_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  int          force_lat   = -1;
  bit          force_rd_en = 1'b0;
  logic [15:0] force_rd    = 16'h0;
  bit          stray_done  = 1'b0;
  bit          model_last  = 1'b0;
  bit          prev_pend[2];
  bus_req_t    prev_req[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input bus_op_t op, input bus_size_t sz,
                         input logic [15:0] a, input logic [15:0] wd);
    if (id == 0) begin
      m0_if.req_op = op; m0_if.req_size = sz; m0_if.req_addr = a; m0_if.req_wdata = wd;
    end else begin
      m1_if.req_op = op; m1_if.req_size = sz; m1_if.req_addr = a; m1_if.req_wdata = wd;
    end
  endtask

  function automatic logic get_done(input int id);
    return (id == 0) ? m0_if.resp_done : m1_if.resp_done;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic master_txn(input int id, input bus_op_t op, input bus_size_t sz,
                            input logic [15:0] a, input logic [15:0] wd);
    int  n;
    logic got;
    set_req(id, op, sz, a, wd);
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = get_done(id);
      n++;
    end
    check($sformatf("resp_wait_m%0d", id), got, 1);
    @(posedge clk); #1;
    set_req(id, BUS_OP_IDLE, BUS_SIZE_BYTE, 16'h0, 16'h0);
  endtask

  task automatic master_loop(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      bus_op_t op;
      op = ($urandom_range(0, 1) != 0) ? BUS_OP_READ : BUS_OP_WRITE;
      master_txn(id, op, bus_size_t'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- MMU responder + arbitration model ----------------
  initial begin : mmu_responder
    bit prev_busy, armed, tmo, win;
    int lat, cnt;
    logic [15:0] rd;
    bus_req_t cur;
    prev_busy = 1'b0; armed = 1'b0; tmo = 1'b0; win = 1'b0;
    lat = 0; cnt = 0; rd = 16'h0;
    s_if.resp_done  = 1'b0;
    s_if.resp_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        armed = 1'b0;
        model_last = 1'b0;
        s_if.resp_done = stray_done;
      end else begin
        if (busy && !prev_busy) begin
          check("pending_at_grant", 32'(prev_pend[0] | prev_pend[1]), 1);
          if (prev_pend[0] && prev_pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = !model_last;
`else
            win = 1'b1;
`endif
          end else begin
            win = prev_pend[1];
          end
          model_last = win;
          cur = prev_req[win];
          check("grant", grant, win);
          check("s_req_op", s_if.req_op, cur.op);
          check("s_req_size", s_if.req_size, cur.size);
          check("s_req_addr", s_if.req_addr, cur.addr);
          check("s_req_wdata", s_if.req_wdata, cur.wdata);
          lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 6);
          rd  = force_rd_en ? force_rd : 16'($urandom);
          tmo = (TMO != 0) && (lat >= TMO);
          exp_q.push_back({16'(cyc + (tmo ? TMO : lat + 1)), win, tmo, tmo ? 16'hFFFF : rd});
          armed = 1'b1;
          cnt = 0;
        end
        if (armed && busy) begin
          s_if.resp_done  = (cnt == lat);
          s_if.resp_rdata = (cnt == lat) ? rd : 16'($urandom);
          if (cnt == lat) armed = 1'b0;
          cnt++;
        end else begin
          armed = 1'b0;
          s_if.resp_done  = stray_done;
          s_if.resp_rdata = 16'($urandom);
        end
        prev_busy = busy;
      end
      prev_pend[0] = (m0_if.req_op != BUS_OP_IDLE);
      prev_pend[1] = (m1_if.req_op != BUS_OP_IDLE);
      prev_req[0]  = {m0_if.req_op, m0_if.req_size, m0_if.req_addr, m0_if.req_wdata};
      prev_req[1]  = {m1_if.req_op, m1_if.req_size, m1_if.req_addr, m1_if.req_wdata};
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : resp_monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && (m0_if.resp_done || m1_if.resp_done || timeout_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {m1_if.resp_done, m0_if.resp_done, timeout_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_done_vec", {m1_if.resp_done, m0_if.resp_done}, e[17] ? 2'b10 : 2'b01);
          check("resp_rdata", e[17] ? m1_if.resp_rdata : m0_if.resp_rdata, e[15:0]);
          check("timeout_err", timeout_err, e[16]);
          check("resp_cycle", cyc[15:0], e[33:18]);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    set_req(0, BUS_OP_IDLE, BUS_SIZE_BYTE, 16'h0, 16'h0);
    set_req(1, BUS_OP_IDLE, BUS_SIZE_BYTE, 16'h0, 16'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_s_op", s_if.req_op, BUS_OP_IDLE);
    check("rst_m0_done", m0_if.resp_done, 0);
    check("rst_m1_rdata", m1_if.resp_rdata, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // single CPU read
    force_lat = 2; force_rd_en = 1'b1; force_rd = 16'h003E;
    master_txn(0, BUS_OP_READ, BUS_SIZE_BYTE, 16'h0100, 16'h0);
    force_rd_en = 1'b0;

    // timeout with no MMU response, then a normal transaction
    force_lat = 20;
    master_txn(0, BUS_OP_READ, BUS_SIZE_WORD, 16'h0200, 16'h0);
    force_lat = 1;
    master_txn(0, BUS_OP_WRITE, BUS_SIZE_WORD, 16'h0202, 16'h5A5A);

    // response on the expiry cycle completes normally
    force_lat = TMO - 1;
    master_txn(1, BUS_OP_READ, BUS_SIZE_WORD, 16'h0300, 16'h0);
    force_lat = -1;

    // four rounds of simultaneous writes
    for (int r = 0; r < 4; r++) begin
      fork
        master_txn(0, BUS_OP_WRITE, BUS_SIZE_WORD, 16'h2000 + 16'(r), 16'hA000 + 16'(r));
        master_txn(1, BUS_OP_WRITE, BUS_SIZE_BYTE, 16'h3000 + 16'(r), 16'hB000 + 16'(r));
      join
    end

    // random concurrent traffic
    fork
      master_loop(0, 25);
      master_loop(1, 25);
    join

    // reset while busy abandons the transaction
    force_lat = 50;
    set_req(0, BUS_OP_READ, BUS_SIZE_WORD, 16'h4242, 16'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    check("busy_before_reset", busy, 1);
    #2; reset = 1'b0; #1;
    check("arst_busy", busy, 0);
    check("arst_grant", grant, 0);
    check("arst_s_op", s_if.req_op, BUS_OP_IDLE);
    check("arst_s_addr", s_if.req_addr, 0);
    check("arst_m0_done", m0_if.resp_done, 0);
    check("arst_m0_rdata", m0_if.resp_rdata, 0);
    check("arst_state", dbg_state, ARB_IDLE);
    exp_q.delete();
    set_req(0, BUS_OP_IDLE, BUS_SIZE_BYTE, 16'h0, 16'h0);
    force_lat = -1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1; stray_done = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_stray_busy", busy, 0);
      check("idle_stray_done", m0_if.resp_done, 0);
    end
    stray_done = 1'b0;
    @(posedge clk); #1;
    master_txn(0, BUS_OP_READ, BUS_SIZE_BYTE, 16'h0500, 16'h0);
    repeat (3) @(posedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
